// File: rtl/pred_pkg.sv
// Shared predictor definitions: branch-kind codes, reset fetch PC and the
// per-fetch metadata record that waits in the FIFO until EX resolves it.
package pred_pkg;

   localparam logic [2:0] NOT_JUMP      = 3'd0;
   localparam logic [2:0] DIRECT_JUMP   = 3'd1;
   localparam logic [2:0] CALL          = 3'd2;
   localparam logic [2:0] RETURN        = 3'd3;
   localparam logic [2:0] COND_BRANCH   = 3'd4;
   localparam logic [2:0] INDIRECT_JUMP = 3'd5;
   localparam logic [2:0] OTHER_JUMP    = 3'd6;

   localparam int          PRED_ADDR_W   = 30;
   localparam int          PRED_GH_W     = 14;
   localparam logic [29:0] PRED_RESET_PC = 30'h0700_0000;

   typedef struct packed {
      logic [PRED_ADDR_W-1:0] pc;
      logic [PRED_ADDR_W-1:0] npc;
      logic [PRED_GH_W-1:0]   gh_hashed;
      logic [2:0]             kind;
      logic                   taken;
   } pred_meta_t;

   localparam int PRED_META_W = $bits(pred_meta_t);

   // Field layout matches pred_meta_t for any address/history width.
   function automatic int meta_width(input int aw, input int gw);
      return 2 * aw + gw + 4;
   endfunction

endpackage

// File: rtl/pc_gen_stage_if.sv
// Fetch-PC stage bus: predictor inputs, EX redirect/pop controls and the
// fetch PC / metadata outputs. slave = the stage, master = its environment.
interface pc_gen_stage_if #(
   parameter int ADDR_WIDTH = 30,
   parameter int gh_width   = 14
);
   logic                  fetch_ready;
   logic [ADDR_WIDTH-1:0] npc_pdc;
   logic [2:0]            kind_pdc;
   logic                  taken_pdc;
   logic                  redirect_en;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [gh_width-1:0]   redirect_ghr;
   logic                  meta_pop;

   logic [ADDR_WIDTH-1:0] pc;
   logic                  pc_valid;
   logic [gh_width-1:0]   pc_gh_hashed;
   logic                  meta_valid;
   logic [ADDR_WIDTH-1:0] meta_pc;
   logic [ADDR_WIDTH-1:0] meta_npc;
   logic [gh_width-1:0]   meta_gh_hashed;
   logic [2:0]            meta_kind;
   logic                  meta_taken;
   logic                  meta_full;

   modport master (
      output fetch_ready, npc_pdc, kind_pdc, taken_pdc,
             redirect_en, redirect_pc, redirect_ghr, meta_pop,
      input  pc, pc_valid, pc_gh_hashed, meta_valid, meta_pc, meta_npc,
             meta_gh_hashed, meta_kind, meta_taken, meta_full
   );

   modport slave (
      input  fetch_ready, npc_pdc, kind_pdc, taken_pdc,
             redirect_en, redirect_pc, redirect_ghr, meta_pop,
      output pc, pc_valid, pc_gh_hashed, meta_valid, meta_pc, meta_npc,
             meta_gh_hashed, meta_kind, meta_taken, meta_full
   );
endinterface

// File: rtl/pred_meta_fifo.sv
// Synchronous FIFO for prediction metadata with a flush that empties it in
// one edge. Pointers carry an extra wrap bit to tell full from empty.
module pred_meta_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_valid,
   output logic             o_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_empty;
   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_do_push = i_push & ~w_full & ~i_flush;
   assign w_do_pop  = i_pop & ~w_empty & ~i_flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
   end

   // Storage is not reset; masking the head keeps the outputs at zero when empty.
   assign o_dout  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
   assign o_valid = ~w_empty;
   assign o_full  = w_full;

endmodule

// File: rtl/pc_gen_stage.sv
// Fetch-PC generation: fetch PC, speculative GHR, hashed predictor index and
// metadata buffering. Define PC_GEN_PERF_CNT_EN to add redirect/stall counters.
module pc_gen_stage
   import pred_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 30,
   parameter int                    gh_width   = 14,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(PRED_RESET_PC),
   parameter int                    META_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   pc_gen_stage_if.slave         bus
`ifdef PC_GEN_PERF_CNT_EN
   ,
   output logic [31:0]           perf_redirects,
   output logic [31:0]           perf_stalls
`endif
);
   localparam int META_W = meta_width(ADDR_WIDTH, gh_width);

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [gh_width-1:0]   r_ghr;
   logic                  r_pc_valid;

   logic                  w_accept;
   logic                  w_full;
   logic                  w_meta_valid;
   logic [gh_width-1:0]   w_hashed;
   logic [META_W-1:0]     w_push_data;
   logic [META_W-1:0]     w_head;

   assign w_hashed = r_pc[gh_width-1:0] ^ r_ghr;
   assign w_accept = r_pc_valid & bus.fetch_ready & ~w_full & ~bus.redirect_en;

   // Redirect beats accept; only real branches shift the history.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc       <= RESET_PC;
         r_ghr      <= '0;
         r_pc_valid <= 1'b0;
      end else begin
         r_pc_valid <= 1'b1;
         if (bus.redirect_en) begin
            r_pc  <= bus.redirect_pc;
            r_ghr <= bus.redirect_ghr;
         end else if (w_accept) begin
            r_pc <= bus.npc_pdc;
            if (bus.kind_pdc != NOT_JUMP) r_ghr <= {r_ghr[gh_width-2:0], bus.taken_pdc};
         end
      end
   end

   assign w_push_data = {r_pc, bus.npc_pdc, w_hashed, bus.kind_pdc, bus.taken_pdc};

   pred_meta_fifo #(
      .WIDTH (META_W),
      .DEPTH (META_DEPTH)
   ) u_meta_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_flush (bus.redirect_en),
      .i_push  (w_accept),
      .i_pop   (bus.meta_pop),
      .i_din   (w_push_data),
      .o_dout  (w_head),
      .o_valid (w_meta_valid),
      .o_full  (w_full)
   );

   assign bus.pc           = r_pc;
   assign bus.pc_valid     = r_pc_valid;
   assign bus.pc_gh_hashed = w_hashed;
   assign bus.meta_valid   = w_meta_valid;
   assign bus.meta_full    = w_full;
   assign {bus.meta_pc, bus.meta_npc, bus.meta_gh_hashed, bus.meta_kind, bus.meta_taken} = w_head;

`ifdef PC_GEN_PERF_CNT_EN
   logic [31:0] r_perf_redirects;
   logic [31:0] r_perf_stalls;
   logic        w_stall;

   assign w_stall = r_pc_valid & ~bus.redirect_en & ~w_accept;

   // Saturating so long runs never wrap back to small values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_perf_redirects <= '0;
         r_perf_stalls    <= '0;
      end else begin
         if (bus.redirect_en && (r_perf_redirects != 32'hFFFF_FFFF))
            r_perf_redirects <= r_perf_redirects + 32'd1;
         if (w_stall && (r_perf_stalls != 32'hFFFF_FFFF))
            r_perf_stalls <= r_perf_stalls + 32'd1;
      end
   end

   assign perf_redirects = r_perf_redirects;
   assign perf_stalls    = r_perf_stalls;
`endif

endmodule

// File: tb/tb_pc_gen_stage.sv
// Randomised bench for pc_gen_stage against a queue-based reference model,
// preceded by directed sequences with hand-computed expectations.
module tb_pc_gen_stage;
   localparam int          AW    = 30;
   localparam int          GW    = 14;
   localparam int          DEPTH = 8;
   localparam logic [29:0] RST   = 30'h0700_0000;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [AW-1:0] npc;
      logic [GW-1:0] gh;
      logic [2:0]    kind;
      logic          taken;
   } ent_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad = 0;

   pc_gen_stage_if #(.ADDR_WIDTH(AW), .gh_width(GW)) bus ();

`ifdef PC_GEN_PERF_CNT_EN
   logic [31:0] perf_r;
   logic [31:0] perf_s;
`endif

   pc_gen_stage #(
      .ADDR_WIDTH (AW),
      .gh_width   (GW),
      .RESET_PC   (RST),
      .META_DEPTH (DEPTH)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
`ifdef PC_GEN_PERF_CNT_EN
      ,
      .perf_redirects (perf_r),
      .perf_stalls    (perf_s)
`endif
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [AW-1:0] m_pc = RST;
   logic [GW-1:0] m_ghr = '0;
   logic          m_valid = 1'b0;
   ent_t          m_q[$];
   logic [31:0]   m_pr = '0;
   logic [31:0]   m_ps = '0;
   bit            m_full;
   bit            m_acc;
   ent_t          m_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_pc = RST; m_ghr = '0; m_valid = 1'b0; m_q.delete(); m_pr = '0; m_ps = '0;
      end else begin
         m_full = (m_q.size() == DEPTH);
         m_acc  = m_valid && bus.fetch_ready && !m_full && !bus.redirect_en;
         if (m_valid && !bus.redirect_en && !m_acc && m_ps != 32'hFFFF_FFFF) m_ps = m_ps + 1;
         if (bus.redirect_en) begin
            if (m_pr != 32'hFFFF_FFFF) m_pr = m_pr + 1;
            m_pc  = bus.redirect_pc;
            m_ghr = bus.redirect_ghr;
            m_q.delete();
         end else begin
            if (bus.meta_pop && m_q.size() > 0) void'(m_q.pop_front());
            if (m_acc) begin
               m_e.pc = m_pc; m_e.npc = bus.npc_pdc; m_e.gh = m_pc[GW-1:0] ^ m_ghr;
               m_e.kind = bus.kind_pdc; m_e.taken = bus.taken_pdc;
               m_q.push_back(m_e);
               if (bus.kind_pdc != 3'd0) m_ghr = {m_ghr[GW-2:0], bus.taken_pdc};
               m_pc = bus.npc_pdc;
            end
         end
         m_valid = 1'b1;
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      chk("pc", 64'(bus.pc), 64'(m_pc));
      chk("pc_valid", 64'(bus.pc_valid), 64'(m_valid));
      chk("pc_gh_hashed", 64'(bus.pc_gh_hashed), 64'(m_pc[GW-1:0] ^ m_ghr));
      chk("meta_valid", 64'(bus.meta_valid), 64'(m_q.size() > 0));
      chk("meta_full", 64'(bus.meta_full), 64'(m_q.size() == DEPTH));
      if (m_q.size() > 0) begin
         chk("meta_pc", 64'(bus.meta_pc), 64'(m_q[0].pc));
         chk("meta_npc", 64'(bus.meta_npc), 64'(m_q[0].npc));
         chk("meta_gh_hashed", 64'(bus.meta_gh_hashed), 64'(m_q[0].gh));
         chk("meta_kind", 64'(bus.meta_kind), 64'(m_q[0].kind));
         chk("meta_taken", 64'(bus.meta_taken), 64'(m_q[0].taken));
      end
`ifdef PC_GEN_PERF_CNT_EN
      chk("perf_redirects", 64'(perf_r), 64'(m_pr));
      chk("perf_stalls", 64'(perf_s), 64'(m_ps));
`endif
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit fr, input bit pop, input logic [2:0] kind, input bit tk);
      bus.fetch_ready  = fr;
      bus.meta_pop     = pop;
      bus.kind_pdc     = kind;
      bus.taken_pdc    = tk;
      bus.redirect_en  = 1'b0;
      bus.redirect_pc  = '0;
      bus.redirect_ghr = '0;
      bus.npc_pdc      = m_pc + AW'(2);
   endtask

   initial begin
      drive(1'b1, 1'b0, 3'd0, 1'b0);
      bus.npc_pdc = RST + AW'(2);
      repeat (3) cyc();

      // Reset state
      chk("rst_pc", 64'(bus.pc), 64'h0700_0000);
      chk("rst_pc_valid", 64'(bus.pc_valid), 64'd0);
      chk("rst_meta_valid", 64'(bus.meta_valid), 64'd0);
      chk("rst_meta_full", 64'(bus.meta_full), 64'd0);
      chk("rst_meta_pc", 64'(bus.meta_pc), 64'd0);
      chk("rst_meta_npc", 64'(bus.meta_npc), 64'd0);
      chk("rst_hashed", 64'(bus.pc_gh_hashed), 64'd0);

      // Sequential fetch, npc = pc + 2
      drive(1'b1, 1'b0, 3'd0, 1'b0);
      rstn = 1'b1;
      cyc();
      chk("t1_valid", 64'(bus.pc_valid), 64'd1);
      chk("t1_pc0", 64'(bus.pc), 64'h0700_0000);
      drive(1'b1, 1'b0, 3'd0, 1'b0); cyc();
      chk("t1_pc1", 64'(bus.pc), 64'h0700_0002);
      drive(1'b1, 1'b0, 3'd0, 1'b0); cyc();
      chk("t1_pc2", 64'(bus.pc), 64'h0700_0004);
      chk("t2_ghr_kind0", 64'(bus.pc_gh_hashed), 64'h0004);

      // Taken branch shifts a 1 into the history
      drive(1'b1, 1'b0, 3'd1, 1'b1); cyc();
      chk("t2_pc", 64'(bus.pc), 64'h0700_0006);
      chk("t2_ghr_taken", 64'(bus.pc_gh_hashed), 64'h0007);

      // Fetch stall holds everything
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 3'd4, 1'b1); cyc();
         chk("t3_pc_hold", 64'(bus.pc), 64'h0700_0006);
         chk("t3_hash_hold", 64'(bus.pc_gh_hashed), 64'h0007);
         chk("t3_head", 64'(bus.meta_pc), 64'h0700_0000);
         chk("t3_full", 64'(bus.meta_full), 64'd0);
      end

      // Fill to full, then pop with fetch_ready high
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b0, 3'd0, 1'b0); cyc();
      end
      chk("t4_full", 64'(bus.meta_full), 64'd1);
      chk("t4_pc_frozen", 64'(bus.pc), 64'h0700_0010);
      chk("t4_hash", 64'(bus.pc_gh_hashed), 64'h0011);
      drive(1'b1, 1'b1, 3'd0, 1'b0); cyc();
      chk("t4_pop_full", 64'(bus.meta_full), 64'd0);
      chk("t4_pop_nopush", 64'(bus.pc), 64'h0700_0010);
      chk("t4_pop_head", 64'(bus.meta_pc), 64'h0700_0002);
      drive(1'b1, 1'b0, 3'd0, 1'b0); cyc();
      chk("t4_resume_pc", 64'(bus.pc), 64'h0700_0012);
      chk("t4_refull", 64'(bus.meta_full), 64'd1);
      for (int i = 0; i < 8; i++) begin
         chk("t4_order", 64'(bus.meta_pc), 64'h0700_0002 + 64'(2 * i));
         drive(1'b0, 1'b1, 3'd0, 1'b0); cyc();
      end
      chk("t4_drained", 64'(bus.meta_valid), 64'd0);

      // Redirect with same-cycle pop and fetch_ready
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 3'd0, 1'b0); cyc();
      end
      chk("t5_head", 64'(bus.meta_pc), 64'h0700_0012);
      drive(1'b1, 1'b1, 3'd2, 1'b1);
      bus.redirect_en = 1'b1; bus.redirect_pc = 30'h123; bus.redirect_ghr = 14'h2A;
      cyc();
      chk("t5_pc", 64'(bus.pc), 64'h123);
      chk("t5_hash", 64'(bus.pc_gh_hashed), 64'h109);
      chk("t5_flushed", 64'(bus.meta_valid), 64'd0);
      drive(1'b0, 1'b0, 3'd0, 1'b0); cyc();
      chk("t5_nopush", 64'(bus.meta_valid), 64'd0);

      // Mid-run reset, then 5 stalls and 2 redirects
      rstn = 1'b0; cyc();
      chk("t6_rst_meta", 64'(bus.meta_valid), 64'd0);
      chk("t6_rst_pc", 64'(bus.pc), 64'h0700_0000);
      drive(1'b0, 1'b0, 3'd0, 1'b0);
      rstn = 1'b1; cyc();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 3'd0, 1'b0); cyc();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 3'd0, 1'b0);
         bus.redirect_en = 1'b1; bus.redirect_pc = 30'h0700_0000; bus.redirect_ghr = 14'h0;
         cyc();
      end
      drive(1'b1, 1'b0, 3'd0, 1'b0); cyc();
`ifdef PC_GEN_PERF_CNT_EN
      chk("t6_redirects", 64'(perf_r), 64'd2);
      chk("t6_stalls", 64'(perf_s), 64'd5);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
               3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
         bus.npc_pdc = ($urandom_range(0, 3) == 0) ? AW'($urandom) : m_pc + AW'($urandom_range(1, 64));
         if ($urandom_range(0, 19) == 0) begin
            bus.redirect_en  = 1'b1;
            bus.redirect_pc  = AW'($urandom);
            bus.redirect_ghr = GW'($urandom);
         end
         cyc();
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
